z80_io_cycle_gen: RTL and testbench

//  Converts raw Z80 I/O bus-cycle signals (IORQ_n, RD_n, WR_n, M1_n, A[7:0]) into clean,

---
 rtl/z80_io_cycle_gen.sv | 166 ++++++++++++++++
 tb/tb_z80_io_cycle_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_cycle_gen.sv
// Z80 I/O bus-cycle generator.
// Turns raw IORQ_n/RD_n/WR_n/M1_n/A[7:0] into registered ioread/iowrite levels,
// a latched port address, a write data strobe, WAIT_n stretching, an
// interrupt-acknowledge pulse and a sticky malformed-cycle flag.
// Optional feature: define Z80IO_SYNC_EN to pass the bus controls through
// 2-flop synchronizers (and the address through a matching delay) when the
// Z80 runs from a clock other than `clock`.
//
// state   | meaning
// IDLE    | waiting for IORQ_n low with a valid RD_n/WR_n/M1_n qualifier
// ACTIVE  | strobe window open, WAIT_n held low while cnt != 0
// RELEASE | strobes low, waiting for IORQ_n high before a new cycle
module z80_io_cycle_gen #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_iorq_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic       cpu_m1_n,
  input  logic [7:0] cpu_addr,
  output logic [7:0] io_addr,
  output logic       ioread,
  output logic       iowrite,
  output logic       io_wr_stb,
  output logic       cpu_wait_n,
  output logic       intack,
  output logic       io_error
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic       iorq_n, rd_n, wr_n, m1_n;
  logic [7:0] addr_s;

`ifdef Z80IO_SYNC_EN
  logic [1:0] iorq_sync, rd_sync, wr_sync, m1_sync;
  logic [7:0] addr_d1, addr_d2;

  // Two-stage synchronizers on the controls, address delayed to stay aligned
  always_ff @(posedge clock) begin
    if (reset) begin
      iorq_sync <= 2'b11;
      rd_sync   <= 2'b11;
      wr_sync   <= 2'b11;
      m1_sync   <= 2'b11;
      addr_d1   <= 8'h00;
      addr_d2   <= 8'h00;
    end else begin
      iorq_sync <= {iorq_sync[0], cpu_iorq_n};
      rd_sync   <= {rd_sync[0], cpu_rd_n};
      wr_sync   <= {wr_sync[0], cpu_wr_n};
      m1_sync   <= {m1_sync[0], cpu_m1_n};
      addr_d1   <= cpu_addr;
      addr_d2   <= addr_d1;
    end
  end

  assign iorq_n = iorq_sync[1];
  assign rd_n   = rd_sync[1];
  assign wr_n   = wr_sync[1];
  assign m1_n   = m1_sync[1];
  assign addr_s = addr_d2;
`else
  assign iorq_n = cpu_iorq_n;
  assign rd_n   = cpu_rd_n;
  assign wr_n   = cpu_wr_n;
  assign m1_n   = cpu_m1_n;
  assign addr_s = cpu_addr;
`endif

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] addr_nxt;
  logic       rd_nxt, wr_nxt, intack_nxt, err_nxt;

  // State, counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      io_addr  <= 8'h00;
      ioread   <= 1'b0;
      iowrite  <= 1'b0;
      intack   <= 1'b0;
      io_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      io_addr  <= addr_nxt;
      ioread   <= rd_nxt;
      iowrite  <= wr_nxt;
      intack   <= intack_nxt;
      io_error <= err_nxt;
    end
  end

  // Next-state decode; direction is fixed when the cycle is accepted
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    addr_nxt   = io_addr;
    rd_nxt     = ioread;
    wr_nxt     = iowrite;
    intack_nxt = 1'b0;
    err_nxt    = io_error;
    case (state)
      IDLE: begin
        if (!iorq_n) begin
          if (!m1_n) begin
            intack_nxt = 1'b1;
            state_nxt  = RELEASE;
          end else if (!rd_n && !wr_n) begin
            err_nxt   = 1'b1;
            state_nxt = RELEASE;
          end else if (!rd_n) begin
            addr_nxt  = addr_s;
            rd_nxt    = 1'b1;
            cnt_nxt   = WAIT_INIT;
            state_nxt = ACTIVE;
          end else if (!wr_n) begin
            addr_nxt  = addr_s;
            wr_nxt    = 1'b1;
            cnt_nxt   = WAIT_INIT;
            state_nxt = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        if (cnt == 4'd0) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = RELEASE;
        end else if (iorq_n) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          err_nxt   = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RELEASE: begin
        rd_nxt = 1'b0;
        wr_nxt = 1'b0;
        if (iorq_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // WAIT_n and the write strobe follow directly from state and counter
  always_comb begin
    cpu_wait_n = !((state == ACTIVE) && (cnt != 4'd0));
    io_wr_stb  = iowrite && (state == ACTIVE) && (cnt == 4'd0);
  end

endmodule

// File: tb/tb_z80_io_cycle_gen.sv
// Bench for z80_io_cycle_gen: two instances (WAIT_CYCLES=2 and 0) each get
// their own stream of bus transactions; the expected output timeline is laid
// out per transaction before the run and compared every cycle.
module tb_z80_io_cycle_gen;

  localparam int NS = 700;
  localparam int NR = NS - 40;
`ifdef Z80IO_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]      rst, iorq_n, rd_n, wr_n, m1_n;
  logic [1:0][7:0] cpu_addr, io_addr;
  logic [1:0]      ioread, iowrite, io_wr_stb, cpu_wait_n, intack, io_error;

  z80_io_cycle_gen #(.WAIT_CYCLES(2)) dut_w2 (
    .clock(clock), .reset(rst[0]), .cpu_iorq_n(iorq_n[0]), .cpu_rd_n(rd_n[0]),
    .cpu_wr_n(wr_n[0]), .cpu_m1_n(m1_n[0]), .cpu_addr(cpu_addr[0]),
    .io_addr(io_addr[0]), .ioread(ioread[0]), .iowrite(iowrite[0]),
    .io_wr_stb(io_wr_stb[0]), .cpu_wait_n(cpu_wait_n[0]), .intack(intack[0]),
    .io_error(io_error[0]));

  z80_io_cycle_gen #(.WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(rst[1]), .cpu_iorq_n(iorq_n[1]), .cpu_rd_n(rd_n[1]),
    .cpu_wr_n(wr_n[1]), .cpu_m1_n(m1_n[1]), .cpu_addr(cpu_addr[1]),
    .io_addr(io_addr[1]), .ioread(ioread[1]), .iowrite(iowrite[1]),
    .io_wr_stb(io_wr_stb[1]), .cpu_wait_n(cpu_wait_n[1]), .intack(intack[1]),
    .io_error(io_error[1]));

  // stimulus per input slot, expectations per output cycle
  bit         in_rst [2][NS];
  bit         in_iorq[2][NS];
  bit         in_rd  [2][NS];
  bit         in_wr  [2][NS];
  bit         in_m1  [2][NS];
  logic [7:0] in_addr[2][NS];
  bit         ex_rd  [2][NS];
  bit         ex_wr  [2][NS];
  bit         ex_stb [2][NS];
  bit         ex_wait[2][NS];
  bit         ex_int [2][NS];
  bit         ev_av  [2][NS];
  logic [7:0] ev_a   [2][NS];
  bit         ev_err [2][NS];
  bit         ev_rst [2][NS];
  logic [7:0] ex_addr[2][NS];
  bit         ex_err [2][NS];

  int tests_run = 0;
  int tests_failed = 0;
  int cur_slot = 0;
  bit run = 1'b0;

  task automatic drv(input int k, input int s, input bit iq, input bit rd, input bit wr,
                     input bit m1, input logic [7:0] a);
    in_iorq[k][s] = iq; in_rd[k][s] = rd; in_wr[k][s] = wr; in_m1[k][s] = m1;
    in_addr[k][s] = a;
  endtask

  task automatic idle_slot(input int k, input int s);
    drv(k, s, 1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
  endtask

  // one strobe-window cycle j of a cycle accepted at input slot s
  task automatic ex_win(input int k, input int w, input int s, input int j, input bit is_wr);
    int n = s + D + j;
    ex_rd[k][n]   = !is_wr;
    ex_wr[k][n]   = is_wr;
    ex_wait[k][n] = (j < w) ? 1'b0 : 1'b1;
    ex_stb[k][n]  = is_wr && (j == w);
  endtask

  // read/write: optional T1 slot, w+1 active slots, e extra low slots, then IORQ high
  task automatic t_rw(input int k, input int w, input bit is_wr, input logic [7:0] a,
                      input int e, input int t1, input bit flip, inout int p);
    bit d;
    if (t1 != 0) begin
      drv(k, p, 1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom));
      p++;
    end
    ev_av[k][p + D] = 1'b1;
    ev_a[k][p + D]  = a;
    for (int j = 0; j <= w; j++) begin
      d = (flip && j > 0) ? !is_wr : is_wr;
      drv(k, p + j, 1'b0, d ? 1'b1 : 1'b0, d ? 1'b0 : 1'b1, 1'b1,
          (j == 0) ? a : 8'($urandom));
      ex_win(k, w, p, j, is_wr);
    end
    p = p + w + 1;
    for (int j = 0; j < e; j++) begin
      drv(k, p, 1'b0, 1'($urandom), 1'($urandom), 1'b1, 8'($urandom));
      p++;
    end
    for (int j = 0; j < ((e == 0) ? 2 : 1); j++) begin
      idle_slot(k, p);
      p++;
    end
  endtask

  // intack (is_ack=1) or RD+WR both low (is_ack=0), then e low slots, then IORQ high
  task automatic t_ack(input int k, input bit is_ack, input int e, inout int p);
    drv(k, p, 1'b0, is_ack, is_ack, !is_ack, 8'($urandom));
    if (is_ack) ex_int[k][p + D] = 1'b1;
    else        ev_err[k][p + D] = 1'b1;
    p++;
    for (int j = 0; j < e; j++) begin
      drv(k, p, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      p++;
    end
    idle_slot(k, p);
    p++;
  endtask

  // IORQ_n rises after kk+1 active cycles while WAIT still pending (kk < w)
  task automatic t_abort(input int k, input int w, input bit is_wr, input logic [7:0] a,
                         input int kk, inout int p);
    ev_av[k][p + D] = 1'b1;
    ev_a[k][p + D]  = a;
    for (int j = 0; j <= kk; j++) begin
      drv(k, p + j, 1'b0, is_wr, !is_wr, 1'b1, a);
      ex_win(k, w, p, j, is_wr);
    end
    ev_err[k][p + D + kk + 1] = 1'b1;
    idle_slot(k, p + kk + 1);
    p = p + kk + 2;
  endtask

  // reset lands kk+1 edges into the strobe window (kk <= w)
  task automatic t_rst_mid(input int k, input int w, input bit is_wr, input logic [7:0] a,
                           input int kk, inout int p);
    int r = p + D + kk + 1;
    ev_av[k][p + D] = 1'b1;
    ev_a[k][p + D]  = a;
    for (int j = 0; j <= kk; j++) ex_win(k, w, p, j, is_wr);
    for (int s = p; s < r; s++) drv(k, s, 1'b0, is_wr, !is_wr, 1'b1, a);
    in_rst[k][r] = 1'b1;
    ev_rst[k][r] = 1'b1;
    p = r + D + 2;
  endtask

  task automatic gen(input int k, input int w);
    int p;
    int r;
    for (int s = 0; s < NS; s++) begin
      idle_slot(k, s);
      in_rst[k][s] = 1'b0;
      ex_rd[k][s] = 1'b0; ex_wr[k][s] = 1'b0; ex_stb[k][s] = 1'b0;
      ex_wait[k][s] = 1'b1; ex_int[k][s] = 1'b0;
      ev_av[k][s] = 1'b0; ev_a[k][s] = 8'h00; ev_err[k][s] = 1'b0; ev_rst[k][s] = 1'b0;
    end
    for (int s = 0; s < 3; s++) begin
      in_rst[k][s] = 1'b1;
      ev_rst[k][s] = 1'b1;
    end
    p = 4;
    t_rw(k, w, 1'b0, 8'h01, 0, 0, 1'b0, p);
    t_rw(k, w, 1'b1, 8'hFF, 0, 0, 1'b0, p);
    t_ack(k, 1'b1, 1, p);
    if (w > 0) t_abort(k, w, 1'b1, 8'h5A, 0, p);
    t_ack(k, 1'b0, 0, p);
    t_rst_mid(k, w, 1'b0, 8'hC3, 0, p);
    while (p < NR) begin
      r = $urandom_range(0, 15);
      if (r <= 2)       begin idle_slot(k, p); p++; end
      else if (r <= 10) t_rw(k, w, (r >= 7), 8'($urandom), $urandom_range(0, 2),
                             $urandom_range(0, 1), 1'($urandom), p);
      else if (r <= 12) t_ack(k, 1'b1, $urandom_range(0, 2), p);
      else if (r == 13) t_ack(k, 1'b0, $urandom_range(0, 2), p);
      else if (r == 14 && w > 0) t_abort(k, w, 1'($urandom), 8'($urandom),
                                         $urandom_range(0, w - 1), p);
      else              t_rst_mid(k, w, 1'($urandom), 8'($urandom), $urandom_range(0, w), p);
    end
  endtask

  // fold address / error events into held per-cycle values
  task automatic sweep(input int k);
    logic [7:0] a = 8'h00;
    bit er = 1'b0;
    for (int n = 0; n < NS; n++) begin
      if (ev_rst[k][n]) begin
        a = 8'h00;
        er = 1'b0;
      end else begin
        if (ev_av[k][n]) a = ev_a[k][n];
        if (ev_err[k][n]) er = 1'b1;
      end
      ex_addr[k][n] = a;
      ex_err[k][n]  = er;
    end
  endtask

  task automatic chk(input string name, input int k, input int n, input logic [7:0] act,
                     input logic [7:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, n, act, req);
    end
  endtask

  // compare process: every output of both instances against the timeline
  always @(posedge clock) begin
    #1;
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        chk("io_addr",    k, cur_slot, io_addr[k],            ex_addr[k][cur_slot]);
        chk("ioread",     k, cur_slot, 8'(ioread[k]),     8'(ex_rd[k][cur_slot]));
        chk("iowrite",    k, cur_slot, 8'(iowrite[k]),    8'(ex_wr[k][cur_slot]));
        chk("io_wr_stb",  k, cur_slot, 8'(io_wr_stb[k]),  8'(ex_stb[k][cur_slot]));
        chk("cpu_wait_n", k, cur_slot, 8'(cpu_wait_n[k]), 8'(ex_wait[k][cur_slot]));
        chk("intack",     k, cur_slot, 8'(intack[k]),     8'(ex_int[k][cur_slot]));
        chk("io_error",   k, cur_slot, 8'(io_error[k]),   8'(ex_err[k][cur_slot]));
      end
      // hand-computed pins for the directed opening transactions
      if (cur_slot == 2) chk("pin_reset_wait", 0, cur_slot, 8'(cpu_wait_n[0]), 8'h01);
      if (cur_slot == 4 + D) begin
        chk("pin_rd_addr",   0, cur_slot, io_addr[0],           8'h01);
        chk("pin_rd_open",   0, cur_slot, 8'(ioread[0]),     8'h01);
        chk("pin_rd_wait",   0, cur_slot, 8'(cpu_wait_n[0]), 8'h00);
        chk("pin_w0_rd",     1, cur_slot, 8'(ioread[1]),     8'h01);
        chk("pin_w0_wait",   1, cur_slot, 8'(cpu_wait_n[1]), 8'h01);
      end
      if (cur_slot == 6 + D) chk("pin_rd_last_wait", 0, cur_slot, 8'(cpu_wait_n[0]), 8'h01);
      if (cur_slot == 7 + D) begin
        chk("pin_rd_closed", 0, cur_slot, 8'(ioread[0]),    8'h00);
        chk("pin_w0_stb",    1, cur_slot, 8'(io_wr_stb[1]), 8'h01);
      end
      if (cur_slot == 10 + D) chk("pin_wr_nostb", 0, cur_slot, 8'(io_wr_stb[0]), 8'h00);
      if (cur_slot == 11 + D) begin
        chk("pin_wr_stb",  0, cur_slot, 8'(io_wr_stb[0]), 8'h01);
        chk("pin_wr_addr", 0, cur_slot, io_addr[0],          8'hFF);
      end
    end
  end

  initial begin
    rst = 2'b11; iorq_n = 2'b11; rd_n = 2'b11; wr_n = 2'b11; m1_n = 2'b11;
    cpu_addr = '0;
    gen(0, 2);
    gen(1, 0);
    sweep(0);
    sweep(1);
    for (int i = 0; i < NS; i++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        rst[k]      = in_rst[k][i];
        iorq_n[k]   = in_iorq[k][i];
        rd_n[k]     = in_rd[k][i];
        wr_n[k]     = in_wr[k][i];
        m1_n[k]     = in_m1[k][i];
        cpu_addr[k] = in_addr[k][i];
      end
      cur_slot = i;
      run = 1'b1;
    end
    @(negedge clock);
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
